// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV immediate generator with a 2-entry skid buffer.
// The immediate is formed combinationally from the incoming instruction and
// captured into the buffer together with its format tag and illegal flag, so
// decode can stall on out_ready without losing anything already accepted.
module imm_gen_pipe #(
  parameter int XLEN        = 64,
  parameter bit AUTO_DECODE = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_I     = 3'd0,
    FMT_S     = 3'd1,
    FMT_B     = 3'd2,
    FMT_U     = 3'd3,
    FMT_J     = 3'd4,
    FMT_SHAMT = 3'd5,
    FMT_CSR   = 3'd6,
    FMT_RAW   = 3'd7
  } fmt_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  fmt_t            dec_fmt;
  logic            dec_ill;
  logic            shamt_narrow;
  logic [XLEN-1:0] dec_imm;

  logic [XLEN-1:0] head_imm;
  logic [2:0]      head_fmt;
  logic            head_ill;
  logic [XLEN-1:0] tail_imm;
  logic [2:0]      tail_fmt;
  logic            tail_ill;
  logic [1:0]      count;
  logic            ready_en;
  logic            push;
  logic            pop;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Pick the format: either straight from sel, or decoded from opcode/funct3.
  // RV64 word shifts (opcode 0011011) only ever use a 5-bit shift amount.
  always_comb begin
    dec_fmt      = FMT_I;
    dec_ill      = 1'b0;
    shamt_narrow = (XLEN == 32);
    if (AUTO_DECODE) begin
      case (opcode)
        7'b0000011, 7'b1100111, 7'b0001111: dec_fmt = FMT_I;
        7'b0010011: begin
          if (funct3 == 3'b001 || funct3 == 3'b101) dec_fmt = FMT_SHAMT;
        end
        7'b0011011: begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            dec_fmt      = FMT_SHAMT;
            shamt_narrow = 1'b1;
          end
        end
        7'b0100011:             dec_fmt = FMT_S;
        7'b1100011:             dec_fmt = FMT_B;
        7'b0110111, 7'b0010111: dec_fmt = FMT_U;
        7'b1101111:             dec_fmt = FMT_J;
        7'b1110011: begin
          if (funct3[2]) dec_fmt = FMT_CSR;
        end
        default:                dec_ill = 1'b1;
      endcase
    end else begin
      dec_fmt = fmt_t'(sel);
    end
  end

  // Assemble the immediate for the chosen format; illegal opcodes yield zero.
  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FMT_I:     dec_imm = XLEN'($signed(instr[31:20]));
      FMT_S:     dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B:     dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U:     dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_J:     dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      FMT_SHAMT: dec_imm = shamt_narrow ? XLEN'(instr[24:20]) : XLEN'(instr[25:20]);
      FMT_CSR:   dec_imm = XLEN'(instr[19:15]);
      FMT_RAW:   dec_imm = XLEN'($signed(instr));
      default:   dec_imm = '0;
    endcase
    if (dec_ill) dec_imm = '0;
  end

  assign in_ready  = ready_en && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign imm     = head_imm;
  assign fmt     = head_fmt;
  assign illegal = head_ill;

  // Hold off in_ready until the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  // Two-slot buffer: head drives the outputs, tail is only non-zero when
  // count is 2, so a pop can always shift tail into head unconditionally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= 2'd0;
      head_imm <= '0;
      head_fmt <= 3'd0;
      head_ill <= 1'b0;
      tail_imm <= '0;
      tail_fmt <= 3'd0;
      tail_ill <= 1'b0;
    end else if (flush) begin
      count    <= 2'd0;
      head_imm <= '0;
      head_fmt <= 3'd0;
      head_ill <= 1'b0;
      tail_imm <= '0;
      tail_fmt <= 3'd0;
      tail_ill <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_imm <= dec_imm;
            head_fmt <= dec_fmt;
            head_ill <= dec_ill;
          end else begin
            tail_imm <= dec_imm;
            tail_fmt <= dec_fmt;
            tail_ill <= dec_ill;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_imm <= tail_imm;
          head_fmt <= tail_fmt;
          head_ill <= tail_ill;
          tail_imm <= '0;
          tail_fmt <= 3'd0;
          tail_ill <= 1'b0;
          count    <= count - 2'd1;
        end
        2'b11: begin
          head_imm <= dec_imm;
          head_fmt <= dec_fmt;
          head_ill <= dec_ill;
        end
        default: ;
      endcase
    end
  end

endmodule
